// File: rtl/io_pkg.sv
// +----------------------------------------------------------------------+
// | io_pkg : shared state encoding and default sizing for io_read_ctrl    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NPORTS  = 4;
  localparam int DEF_TIMEOUT = 255;
  localparam int PORT_W      = 3;
  localparam int TIMER_W     = 8;

endpackage

`default_nettype wire

// File: rtl/io_read_ctrl_if.sv
// +----------------------------------------------------------------------+
// | io_read_ctrl_if : sequencer request / port bus bundle with modports   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface io_read_ctrl_if #(
  parameter int WIDTH  = io_pkg::DEF_WIDTH,
  parameter int NPORTS = io_pkg::DEF_NPORTS
);
  import io_pkg::*;

  logic                rd_req;
  logic [PORT_W-1:0]   rd_port;
  logic [NPORTS-1:0]   ok2send;
  logic [WIDTH-1:0]    bus_q;
  logic [NPORTS-1:0]   oe;
  logic                stall;
  logic [WIDTH-1:0]    rd_data;
  logic                rd_valid;
  logic                rd_err;

  // master: sequencer plus port side; slave: the read controller
  modport master (
    output rd_req, rd_port, ok2send, bus_q,
    input  oe, stall, rd_data, rd_valid, rd_err
  );

  modport slave (
    input  rd_req, rd_port, ok2send, bus_q,
    output oe, stall, rd_data, rd_valid, rd_err
  );

endinterface

`default_nettype wire

// File: rtl/io_read_ctrl_onehot_dec.sv
// +----------------------------------------------------------------------+
// | onehot_dec : index plus enable to N-bit one-hot (all zero if !en)    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module onehot_dec #(
  parameter int N     = io_pkg::DEF_NPORTS,
  parameter int IDX_W = io_pkg::PORT_W
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N-1:0]     onehot
);
  import io_pkg::*;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign onehot[i] = en && (idx == IDX_W'(i));
  end

endmodule

`default_nettype wire

// File: rtl/io_read_ctrl.sv
// +----------------------------------------------------------------------+
// | io_read_ctrl : reads one word from a selected port on a shared bus,   |
// | with per-read timeout and bad-port rejection.  Revision: 1.0          |
// +----------------------------------------------------------------------+
`default_nettype none

module io_read_ctrl #(
  parameter int WIDTH   = io_pkg::DEF_WIDTH,
  parameter int NPORTS  = io_pkg::DEF_NPORTS,
  parameter int TIMEOUT = io_pkg::DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           reset,
  io_read_ctrl_if.slave  bus
);
  import io_pkg::*;

  state_t               state, state_next;
  logic [PORT_W-1:0]    port_sel, port_sel_next;
  logic [TIMER_W-1:0]   timer, timer_next;
  logic [WIDTH-1:0]     data_reg, data_next;
  logic                 err, err_next;

  logic                 busy;
  logic                 port_ok;
  logic                 sel_ready;
  logic [NPORTS-1:0]    oe_vec;

  assign busy    = (state == SETUP) || (state == WAIT);
  assign port_ok = int'(bus.rd_port) < NPORTS;

  onehot_dec #(
    .N     (NPORTS),
    .IDX_W (PORT_W)
  ) u_oe_dec (
    .idx    (port_sel),
    .en     (busy),
    .onehot (oe_vec)
  );

  // oe is one-hot on port_sel during WAIT, so it doubles as the ready mask
  assign sel_ready = |(bus.ok2send & oe_vec);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      port_sel <= '0;
      timer    <= '0;
      data_reg <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      port_sel <= port_sel_next;
      timer    <= timer_next;
      data_reg <= data_next;
      err      <= err_next;
    end
  end

  always_comb begin
    state_next    = state;
    port_sel_next = port_sel;
    timer_next    = timer;
    data_next     = data_reg;
    err_next      = err;
    unique case (state)
      IDLE: begin
        if (bus.rd_req) begin
          if (port_ok) begin
            port_sel_next = bus.rd_port;
            timer_next    = '0;
            state_next    = SETUP;
          end else begin
            data_next  = '0;
            err_next   = 1'b1;
            state_next = DONE;
          end
        end
      end
      SETUP: state_next = WAIT;
      WAIT: begin
        // ready is checked before expiry so a late ready still succeeds
        if (sel_ready) begin
          data_next  = bus.bus_q;
          err_next   = 1'b0;
          state_next = DONE;
        end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
          data_next  = '0;
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.oe       = oe_vec;
  assign bus.stall    = busy;
  assign bus.rd_data  = data_reg;
  assign bus.rd_valid = (state == DONE);
  assign bus.rd_err   = err && (state == DONE);

endmodule

`default_nettype wire

// File: doc/io_read_ctrl.md
IO_READ_CTRL -- requirements
Module: io_read_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, data width of the shared input bus.
REQ-002 Parameter NPORTS, default 4, number of input ports served (1..8).
REQ-003 Parameter TIMEOUT, default 255, maximum WAIT cycles before abort (1..255).
REQ-004 clk  input  1  system clock; all state changes on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset; one clock domain only.
REQ-006 rd_req  input  1  read request from the sequencer; sampled only in IDLE.
REQ-007 rd_port  input  3  port index for the request; sampled with rd_req.
REQ-008 ok2send  input  NPORTS  per-port data-ready level; bit i belongs to port i.
REQ-009 bus_q  input  WIDTH  shared tri-stated port bus, driven by the port whose oe is high.
REQ-010 oe  output  NPORTS  one-hot (or zero) output-enable to the ports.
REQ-011 stall  output  1  holds the sequencer while a read is in progress.
REQ-012 rd_data  output  WIDTH  registered captured data.
REQ-013 rd_valid  output  1  one-cycle pulse: rd_data and rd_err are valid.
REQ-014 rd_err  output  1  transaction failed (bad port or timeout); meaningful only with rd_valid.

Function
REQ-015 The FSM SHALL have states IDLE, SETUP, WAIT, DONE, registered, with encoding from the package.
REQ-016 IDLE: when rd_req=1 and rd_port<NPORTS -> latch port_sel=rd_port, clear timer -> SETUP; when rd_req=1 and rd_port>=NPORTS -> DONE with err=1, rd_data=0.
REQ-017 SETUP: lasts exactly one cycle (bus settle) -> WAIT.
REQ-018 WAIT: when ok2send[port_sel]=1 -> capture bus_q into rd_data, err=0 -> DONE.
REQ-019 WAIT: when ok2send[port_sel]=0, the timer increments. When the timer reaches TIMEOUT-1 -> rd_data=0, err=1 -> DONE. Total WAIT time is therefore TIMEOUT cycles.
REQ-020 DONE: rd_valid=1 for exactly one cycle -> IDLE unconditionally. rd_req seen in DONE is ignored.
REQ-021 oe[port_sel]=1 in SETUP and WAIT only. All other oe bits are 0 at all times; oe=0 in IDLE and DONE.
REQ-022 stall=1 in SETUP and WAIT; 0 in IDLE and DONE. It is decoded from state, with no combinational path from inputs.
REQ-023 Minimum latency: rd_req sampled at edge N, ok2send already high -> rd_valid high in cycle N+3.
REQ-024 ok2send bits of non-selected ports SHALL be ignored. ok2send is treated as a level, not an edge.
REQ-025 rd_data SHALL hold its value from one DONE to the next. rd_err SHALL equal the latched err while rd_valid=1 and 0 otherwise.
REQ-026 If ok2send and timer expiry occur in the same WAIT cycle, ok2send wins (successful capture, err=0).
REQ-027 The timer SHALL be 8 bits wide and never wrap; it is cleared when entering SETUP.

Reset
REQ-028 reset=1 at a clock edge SHALL force state=IDLE, port_sel=0, timer=0, rd_data=0, err=0. Outputs are then oe=0, stall=0, rd_valid=0, rd_err=0.
REQ-029 reset in SETUP/WAIT SHALL abort the read silently: no rd_valid, and oe drops at that edge.
REQ-030 reset has priority over every other input, including rd_req in the same cycle.

Structure
REQ-031 Package io_pkg SHALL hold the state typedef/encoding (IDLE=0, SETUP=1, WAIT=2, DONE=3) and the default WIDTH/NPORTS/TIMEOUT constants.
REQ-032 One sub-module, onehot_dec (index plus enable -> NPORTS-bit one-hot), SHALL generate oe. Everything else stays in io_read_ctrl.

Verification
REQ-033 Fast read: reset 2 cycles, bus_q=5, ok2send=4'b0001, rd_req/rd_port=0 pulse at edge 3 -> oe=0001 in cycles 4-5, rd_valid with rd_data=5, rd_err=0 in cycle 6, stall high in cycles 4-5 only.
REQ-034 Slow read: rd_port=2, ok2send[2] rises 10 cycles after SETUP, bus_q=8'hA7 -> oe=0100 throughout, rd_data=A7, rd_err=0, stall high for 11 cycles.
REQ-035 Timeout: TIMEOUT=4, rd_port=1, ok2send=0 -> exactly 4 WAIT cycles, then rd_valid, rd_err=1, rd_data=0, oe back to 0.
REQ-036 Bad port: rd_port=6 with NPORTS=4 -> next cycle rd_valid, rd_err=1, oe never asserted, stall never asserted.
REQ-037 Reset mid-WAIT: reset pulse during WAIT of a port-3 read -> oe=0, stall=0 next cycle, no rd_valid. A subsequent read completes normally.
REQ-038 Wrong-port ready plus back-to-back: ok2send=4'b1110 with rd_port=0 -> no capture until bit 0 rises. An rd_req held high through DONE is accepted only on return to IDLE, giving one read per 4 cycles minimum.
